// File: rtl/gpu_pkg.sv
// gpu_pkg: opcodes, scheduler state encoding and the queued command entry shared by the scheduler files.
package gpu_pkg;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,
        OP_BLIT  = 2'd1,
        OP_READ  = 2'd2,
        OP_WRITE = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COMPLETE
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [8:0] x1;
        logic [8:0] x2;
        logic [7:0] y1;
        logic [7:0] y2;
        logic [8:0] w;
        logic [7:0] h;
        logic       value;
        logic [7:0] wbyte;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: power-of-two circular command queue with occupancy count.
module gpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 62
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full  = level_q == (AW+1)'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    assign rdata = mem[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// gpu_cmd_scheduler: queues drawing commands and sequences them one at a time onto the pixel engine.
// Define GPU_CMD_SCHED_BOUNDS_CHECK_EN to reject off-screen coordinates before they reach the engine.
module gpu_cmd_scheduler
    import gpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [8:0]             cmd_x1,
    input  logic [8:0]             cmd_x2,
    input  logic [7:0]             cmd_y1,
    input  logic [7:0]             cmd_y2,
    input  logic [8:0]             cmd_w,
    input  logic [7:0]             cmd_h,
    input  logic                   cmd_value,
    input  logic [7:0]             cmd_byte,
    output logic [8:0]             eng_x1,
    output logic [8:0]             eng_x2,
    output logic [7:0]             eng_y1,
    output logic [7:0]             eng_y2,
    output logic [8:0]             eng_w,
    output logic [7:0]             eng_h,
    output logic                   eng_fill_value,
    output logic [7:0]             eng_write_byte,
    output logic                   eng_start_fill,
    output logic                   eng_start_blit,
    output logic                   eng_start_read,
    output logic                   eng_start_write,
    input  logic                   eng_busy,
    input  logic                   eng_error,
    input  logic                   eng_byte_ready,
    input  logic [7:0]             eng_byte,
    output logic                   done,
    output logic                   done_err,
    output logic [7:0]             rd_byte,
    output logic [$clog2(DEPTH):0] level,
    output logic                   idle
);
`ifdef GPU_CMD_SCHED_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d, head, push_cmd;
    logic       err_q, err_d, cnt_q, cnt_d;
    logic [7:0] rd_byte_q, rd_byte_d;
    logic       empty, full, pop, oob;

    assign push_cmd = '{op: op_e'(cmd_op), x1: cmd_x1, x2: cmd_x2, y1: cmd_y1, y2: cmd_y2,
                        w: cmd_w, h: cmd_h, value: cmd_value, wbyte: cmd_byte};
    assign cmd_ready = !full;

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata (push_cmd),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign oob = BOUNDS_CHECK && (head.x1 > 9'(WIDTH) || head.x2 > 9'(WIDTH) ||
                                  head.y1 > 8'(HEIGHT) || head.y2 > 8'(HEIGHT));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        rd_byte_d = rd_byte_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: if (!empty && !eng_busy) begin
                pop     = 1'b1;
                cmd_d   = head;
                err_d   = oob;
                cnt_d   = 1'b0;
                state_d = oob ? S_COMPLETE : S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT_BUSY;
            // An engine that never raises busy has rejected the command.
            S_WAIT_BUSY: if (eng_busy) begin
                state_d = S_WAIT_DONE;
            end else if (cnt_q) begin
                state_d = S_COMPLETE;
                err_d   = eng_error;
            end else begin
                cnt_d = 1'b1;
            end
            S_WAIT_DONE: if (!eng_busy) begin
                state_d   = S_COMPLETE;
                err_d     = eng_error;
                rd_byte_d = (cmd_q.op == OP_READ && eng_byte_ready) ? eng_byte : rd_byte_q;
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= 1'b0;
            rd_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rd_byte_q <= rd_byte_d;
        end
    end

    assign eng_x1          = cmd_q.x1;
    assign eng_x2          = cmd_q.x2;
    assign eng_y1          = cmd_q.y1;
    assign eng_y2          = cmd_q.y2;
    assign eng_w           = cmd_q.w;
    assign eng_h           = cmd_q.h;
    assign eng_fill_value  = cmd_q.value;
    assign eng_write_byte  = cmd_q.wbyte;
    assign eng_start_fill  = state_q == S_ISSUE && cmd_q.op == OP_FILL;
    assign eng_start_blit  = state_q == S_ISSUE && cmd_q.op == OP_BLIT;
    assign eng_start_read  = state_q == S_ISSUE && cmd_q.op == OP_READ;
    assign eng_start_write = state_q == S_ISSUE && cmd_q.op == OP_WRITE;
    assign done            = state_q == S_COMPLETE;
    assign done_err        = done && err_q;
    assign rd_byte         = rd_byte_q;
    assign idle            = empty && state_q == S_IDLE;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// tb_gpu_cmd_scheduler: directed and randomized checks of the command scheduler against a queue-based model
// and a simple engine that rejects off-screen commands and answers READs with write_byte^0x3C.
module tb_gpu_cmd_scheduler;
    import gpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 320;
    localparam int H     = 200;
`ifdef GPU_CMD_SCHED_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_t       drv = '0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [8:0] eng_x1, eng_x2, eng_w;
    logic [7:0] eng_y1, eng_y2, eng_h, eng_write_byte;
    logic       eng_fill_value;
    logic       eng_start_fill, eng_start_blit, eng_start_read, eng_start_write;
    logic       eng_busy, eng_error = 1'b0, eng_byte_ready = 1'b0;
    logic [7:0] eng_byte = '0;
    logic       done, done_err, idle;
    logic [7:0] rd_byte;
    logic [$clog2(DEPTH):0] level;

    gpu_cmd_scheduler #(.DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(drv.op), .cmd_x1(drv.x1), .cmd_x2(drv.x2), .cmd_y1(drv.y1), .cmd_y2(drv.y2),
        .cmd_w(drv.w), .cmd_h(drv.h), .cmd_value(drv.value), .cmd_byte(drv.wbyte),
        .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2), .eng_w(eng_w),
        .eng_h(eng_h), .eng_fill_value(eng_fill_value), .eng_write_byte(eng_write_byte),
        .eng_start_fill(eng_start_fill), .eng_start_blit(eng_start_blit),
        .eng_start_read(eng_start_read), .eng_start_write(eng_start_write),
        .eng_busy(eng_busy), .eng_error(eng_error), .eng_byte_ready(eng_byte_ready),
        .eng_byte(eng_byte), .done(done), .done_err(done_err), .rd_byte(rd_byte),
        .level(level), .idle(idle)
    );

    function automatic bit off_screen(input logic [8:0] x1, x2, input logic [7:0] y1, y2);
        return int'(x1) > W || int'(x2) > W || int'(y1) > H || int'(y2) > H;
    endfunction

    logic [3:0]  strobes;
    logic [59:0] eng_ops;
    assign strobes = {eng_start_write, eng_start_read, eng_start_blit, eng_start_fill};
    assign eng_ops = {eng_x1, eng_x2, eng_y1, eng_y2, eng_w, eng_h, eng_fill_value, eng_write_byte};

    // Engine model: busy for a while after a strobe, or error without busy when off-screen.
    logic model_busy = 1'b0, hold_busy = 1'b0, is_read = 1'b0;
    int   busy_fixed = 0, busy_cnt = 0;
    assign eng_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        if (eng_byte_ready) eng_byte_ready <= 1'b0;
        if (strobes != 0) begin
            eng_error <= off_screen(eng_x1, eng_x2, eng_y1, eng_y2);
            if (!off_screen(eng_x1, eng_x2, eng_y1, eng_y2)) begin
                model_busy <= 1'b1;
                busy_cnt   <= busy_fixed > 0 ? busy_fixed : int'($urandom_range(1, 6));
                is_read    <= eng_start_read;
            end
        end else if (model_busy) begin
            if (busy_cnt <= 1) begin
                model_busy <= 1'b0;
                if (is_read) begin
                    eng_byte_ready <= 1'b1;
                    eng_byte       <= eng_write_byte ^ 8'h3C;
                end
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Monitor: records issued commands and completions, flags multi-strobes and operand drift.
    cmd_t       issued_q[$];
    logic [8:0] done_q[$];
    cmd_t       mon_c, snap;
    logic       active = 1'b0;
    int         n_done = 0, multi_strobe = 0, unstable = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (strobes != 0) begin
                if ($countones(strobes) != 1) multi_strobe++;
                mon_c = cmd_t'({strobes[3] ? 2'd3 : strobes[2] ? 2'd2 : strobes[1] ? 2'd1 : 2'd0, eng_ops});
                issued_q.push_back(mon_c);
                snap   = mon_c;
                active = 1'b1;
            end else if (active && eng_ops != snap[59:0]) begin
                unstable++;
            end
            if (done) begin
                n_done++;
                done_q.push_back({done_err, rd_byte});
                active = 1'b0;
            end
        end else begin
            active = 1'b0;
        end
    end

    int   vectors = 0, miscompares = 0;
    cmd_t exp_q[$];
    logic [7:0] last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input cmd_t c);
        int t = 0;
        @(negedge clk);
        drv       = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        exp_q.push_back(c);
    endtask

    task automatic drain();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(idle && !eng_busy) && t < 3000);
        chk("drain_idle", idle, 1);
    endtask

    task automatic verify(input string tag);
        cmd_t       exp_iss[$];
        logic [8:0] exp_done[$];
        foreach (exp_q[i]) begin
            bit oob = off_screen(exp_q[i].x1, exp_q[i].x2, exp_q[i].y1, exp_q[i].y2);
            if (!(BCHK && oob)) exp_iss.push_back(exp_q[i]);
            if (exp_q[i].op == OP_READ && !oob) last_rd = exp_q[i].wbyte ^ 8'h3C;
            exp_done.push_back({oob, last_rd});
        end
        chk({tag, "_n_issued"}, issued_q.size(), exp_iss.size());
        chk({tag, "_n_done"}, done_q.size(), exp_done.size());
        foreach (exp_iss[i]) if (i < issued_q.size()) chk({tag, "_issued"}, issued_q[i], exp_iss[i]);
        foreach (exp_done[i]) if (i < done_q.size()) chk({tag, "_err_rd"}, done_q[i], exp_done[i]);
        chk({tag, "_multi_strobe"}, multi_strobe, 0);
        chk({tag, "_unstable"}, unstable, 0);
        exp_q.delete();
        issued_q.delete();
        done_q.delete();
    endtask

    function automatic cmd_t mk(input op_e op, input int x1, x2, y1, y2, w, h, input logic v, input logic [7:0] b);
        return '{op: op, x1: 9'(x1), x2: 9'(x2), y1: 8'(y1), y2: 8'(y2), w: 9'(w), h: 8'(h), value: v, wbyte: b};
    endfunction

    initial begin
        int   n0;
        cmd_t c;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_idle", idle, 1);
        chk("rst_done", {done, done_err}, 0);
        chk("rst_strobes", strobes, 0);
        chk("rst_rd_byte", rd_byte, 0);
        chk("rst_ops", eng_ops, 0);
        chk("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // Single FILL with a long engine busy
        busy_fixed = 50;
        push_cmd(mk(OP_FILL, 0, 9, 0, 4, 9, 4, 1'b1, 8'h00));
        drain();
        verify("fill");

        // Four back-to-back while the engine is held busy
        busy_fixed = 3;
        hold_busy  = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(mk(op_e'(i), 10 * i, 10 * i + 5, i, i + 7, 5, 7, i[0], 8'(16 * i + 1)));
        @(negedge clk);
        chk("full_level", level, 4);
        chk("full_ready", cmd_ready, 0);
        drv       = mk(OP_FILL, 1, 2, 3, 4, 5, 6, 1'b0, 8'hEE);
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        chk("full_ignored", level, 4);
        hold_busy = 1'b0;
        drain();
        verify("order4");

        // READ returning 0xA5, then a FILL must not disturb rd_byte
        push_cmd(mk(OP_READ, 8, 8, 3, 3, 1, 1, 1'b0, 8'h99));
        drain();
        verify("read");
        chk("read_byte", rd_byte, 8'hA5);
        push_cmd(mk(OP_FILL, 1, 2, 1, 2, 1, 1, 1'b1, 8'h00));
        drain();
        verify("hold_rd");
        chk("read_hold", rd_byte, 8'hA5);

        // Off-screen FILL
        push_cmd(mk(OP_FILL, 400, 410, 0, 4, 10, 4, 1'b1, 8'h00));
        drain();
        verify("oob");

        // Push at DEPTH-1 on the same cycle as a pop
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(mk(OP_WRITE, i, i + 1, i, i + 2, 1, 2, 1'b0, 8'(8'h40 + i)));
        @(negedge clk);
        chk("pp_level_pre", level, 3);
        c         = mk(OP_WRITE, 30, 31, 30, 32, 1, 2, 1'b1, 8'h7F);
        drv       = c;
        cmd_valid = 1'b1;
        hold_busy = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        exp_q.push_back(c);
        @(negedge clk);
        chk("pp_level_post", level, 3);
        drain();
        verify("pushpop");

        // Reset during WAIT_DONE of a BLIT with two queued
        busy_fixed = 30;
        push_cmd(mk(OP_BLIT, 0, 50, 0, 50, 50, 50, 1'b0, 8'h00));
        push_cmd(mk(OP_FILL, 5, 6, 5, 6, 1, 1, 1'b1, 8'h00));
        push_cmd(mk(OP_FILL, 7, 8, 7, 8, 1, 1, 1'b1, 8'h00));
        repeat (8) @(negedge clk);
        chk("mid_level", level, 2);
        n0    = n_done;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_ops", eng_ops, 0);
        chk("mid_rst_done", {done, strobes}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_no_done", n_done, n0);
        chk("mid_idle", idle, 1);
        exp_q.delete();
        issued_q.delete();
        done_q.delete();
        last_rd    = '0;
        busy_fixed = 0;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            c.op    = op_e'($urandom_range(0, 3));
            c.x1    = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(321, 511)) : 9'($urandom_range(0, 320));
            c.x2    = 9'($urandom_range(0, 320));
            c.y1    = 8'($urandom_range(0, 200));
            c.y2    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(201, 255)) : 8'($urandom_range(0, 200));
            c.w     = 9'($urandom);
            c.h     = 8'($urandom);
            c.value = 1'($urandom);
            c.wbyte = 8'($urandom);
            push_cmd(c);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        verify("random");
        chk("random_rd_byte", rd_byte, last_rd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_scheduler.md
GPU_CMD_SCHEDULER -- requirements
Module: gpu_cmd_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, 320, screen width used for bounds check.
REQ-003 SHALL have parameter HEIGHT, 200, screen height used for bounds check.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid/cmd_ready  input/output  1/1  command push handshake.
REQ-007 SHALL have port cmd_op  input  2  0=FILL, 1=BLIT, 2=READ, 3=WRITE.
REQ-008 SHALL have ports cmd_x1/cmd_x2 (9), cmd_y1/cmd_y2 (8), cmd_w (9), cmd_h (8), cmd_value (1), cmd_byte (8)  input  command operands.
REQ-009 SHALL have ports eng_x1/eng_x2 (9), eng_y1/eng_y2 (8), eng_w (9), eng_h (8), eng_fill_value (1), eng_write_byte (8)  output  engine operands.
REQ-010 SHALL have ports eng_start_fill, eng_start_blit, eng_start_read, eng_start_write  output  1  engine start strobes.
REQ-011 SHALL have ports eng_busy, eng_error, eng_byte_ready  input  1  and eng_byte  input  8  engine status.
REQ-012 SHALL have ports done  output  1  completion pulse; done_err  output  1  error of that command; rd_byte  output  8  READ result; level  output  $clog2(DEPTH)+1  FIFO occupancy; idle  output  1  FIFO empty and FSM in IDLE.

Function
REQ-013 FIFO SHALL store op plus all operands (62 bits/entry); push when cmd_valid&&cmd_ready; cmd_ready = (level<DEPTH).
REQ-014 Simultaneous push and pop SHALL keep level unchanged; push at full SHALL be ignored; pop at empty SHALL never occur.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
REQ-016 IDLE: if FIFO non-empty and eng_busy=0, pop head into operand registers -> ISSUE.
REQ-017 ISSUE: assert exactly one start strobe matching op for one cycle -> WAIT_BUSY.
REQ-018 WAIT_BUSY: eng_busy=1 -> WAIT_DONE; else after 2 cycles without busy -> COMPLETE with done_err=eng_error (engine-rejected command).
REQ-019 WAIT_DONE: on eng_busy=0 -> COMPLETE; for READ, rd_byte SHALL capture eng_byte in that cycle when eng_byte_ready=1.
REQ-020 COMPLETE: done=1 for one cycle, done_err valid same cycle -> IDLE; minimum command-to-command spacing 4 cycles.
REQ-021 eng_* operands SHALL remain stable from ISSUE until COMPLETE inclusive (engine samples direction live during BLIT).
REQ-022 Strobes SHALL be 0 in every state other than ISSUE.
REQ-023 rd_byte SHALL hold its value until the next completed READ.

Reset
REQ-024 rst_n low SHALL immediately clear FIFO pointers, level=0, FSM=IDLE, all strobes=0, done=0, done_err=0, rd_byte=0, eng_* operands=0.
REQ-025 Reset mid-command SHALL abandon it silently (no done pulse); the engine is not reset by this block.

Configuration
REQ-026 Macro GPU_CMD_SCHED_BOUNDS_CHECK_EN defined: in IDLE, a popped command with x1/x2>WIDTH or y1/y2>HEIGHT SHALL skip ISSUE and go directly to COMPLETE with done_err=1, no strobe.
REQ-027 Macro undefined: no pre-check; all commands issued, errors reported only via eng_error per REQ-018.

Structure
REQ-028 Shared package gpu_pkg SHALL hold opcode constants, state encoding and the command entry struct/width constant.
REQ-029 FIFO SHALL be sub-module gpu_cmd_fifo (DEPTH, data width params); FSM in the top.

Verification
REQ-030 FILL (0,0)-(9,4) w=9 h=4 pushed, engine model busy 50 cycles -> one eng_start_fill pulse, done=1 once, done_err=0.
REQ-031 Four commands pushed back-to-back with DEPTH=4 -> cmd_ready=0 after 4th accepted, level=4, executed in order, four done pulses.
REQ-032 READ at (8,3), engine returns eng_byte=0xA5 with eng_byte_ready as busy falls -> rd_byte=0xA5 at done.
REQ-033 FILL x1=400: with macro -> done_err=1, no strobe; without -> strobe issued, engine error, no busy -> done_err=1 after 2-cycle timeout.
REQ-034 rst_n low during WAIT_DONE of BLIT with 2 queued -> level=0, idle=1, no done pulse, operands 0.
REQ-035 Push at level=DEPTH-1 on same cycle as pop -> level unchanged, no data lost or duplicated.
